// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg
// Shared constants for the memory-mapped UART: register byte offsets,
// STATUS / CTRL bit positions and the TX engine state encoding.
package uart_mmio_pkg;

  // Register byte offsets
  localparam int unsigned OFF_DATA   = 'h0;
  localparam int unsigned OFF_STATUS = 'h4;
  localparam int unsigned OFF_COUNT  = 'h8;
  localparam int unsigned OFF_CTRL   = 'hC;

  // STATUS bit positions
  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_TX_OVF   = 5;

  // CTRL bit positions
  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_FLUSH   = 2;

  // TX engine states
  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_mmio_fifo.sv
// sync_fifo
// Single-clock FIFO with a combinational head output.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   push, din       write strobe and data (ignored when full unless popping)
//   pop             read strobe (ignored when empty)
//   flush           empties the FIFO; wins over push and pop
//   dout            current head entry
//   full, empty     occupancy flags
//   count           occupancy, DEPTH_LOG2+1 bits
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio
// Memory-mapped UART front end: bus register decode, RX/TX FIFOs, sticky
// overflow flags, flush control, receive interrupt and TX frame pacing.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   bus_en/we/addr/wdata                register access, sampled each edge
//   bus_rdata, bus_rvalid               read return, valid after the next edge
//   uart_rx_data, uart_rx_last          byte strobe from the receiver PHY
//   uart_tx_data, uart_tx_start         byte and start pulse to the transmitter PHY
//   irq                                 level, irq_en & RX FIFO non-empty
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 4,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int CLKS_PER_FRAME  = 8680
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      bus_en,
  input  logic                      bus_we,
  input  logic [REG_ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0]     bus_wdata,
  output logic [DATA_WIDTH-1:0]     bus_rdata,
  output logic                      bus_rvalid,
  input  logic [7:0]                uart_rx_data,
  input  logic                      uart_rx_last,
  output logic [7:0]                uart_tx_data,
  output logic                      uart_tx_start,
  output logic                      irq
);
  localparam int CNT_W = $clog2(CLKS_PER_FRAME);
  localparam int FL    = FIFO_DEPTH_LOG2;

  logic rd_acc, wr_acc;
  logic hit_data, hit_status, hit_count, hit_ctrl;
  logic flush, clr_ovf;
  logic rx_pop, rx_full, rx_empty, rx_ovf, rx_ovf_set;
  logic tx_push, tx_pop, tx_full, tx_empty, tx_ovf, tx_ovf_set;
  logic irq_en;
  logic [7:0] rx_dout, tx_dout;
  logic [FL:0] rx_count, tx_count;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  rd_vld_p1;
  logic                  wdata_unused;

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_d;

  assign rd_acc     = bus_en & ~bus_we;
  assign wr_acc     = bus_en & bus_we;
  assign hit_data   = (bus_addr == REG_ADDR_WIDTH'(OFF_DATA));
  assign hit_status = (bus_addr == REG_ADDR_WIDTH'(OFF_STATUS));
  assign hit_count  = (bus_addr == REG_ADDR_WIDTH'(OFF_COUNT));
  assign hit_ctrl   = (bus_addr == REG_ADDR_WIDTH'(OFF_CTRL));

  assign flush   = wr_acc & hit_ctrl & bus_wdata[CTRL_FLUSH];
  assign clr_ovf = wr_acc & hit_ctrl & bus_wdata[CTRL_CLR_OVF];
  assign wdata_unused = ^bus_wdata[DATA_WIDTH-1:8];

  assign rx_pop     = rd_acc & hit_data & ~rx_empty;
  assign tx_push    = wr_acc & hit_data;
  // A byte is lost only when full and nothing leaves in the same cycle.
  assign rx_ovf_set = uart_rx_last & rx_full & ~rx_pop;
  assign tx_ovf_set = tx_push & tx_full & ~tx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(FL)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(uart_rx_last), .pop(rx_pop), .flush(flush),
    .din(uart_rx_data), .dout(rx_dout), .full(rx_full), .empty(rx_empty),
    .count(rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(FL)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .flush(flush),
    .din(bus_wdata[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty),
    .count(tx_count)
  );

  always_comb begin
    rd_word = '0;
    if (hit_data) begin
      rd_word[7:0] = rx_empty ? 8'h00 : rx_dout;
    end else if (hit_status) begin
      rd_word[ST_RX_EMPTY] = rx_empty;
      rd_word[ST_RX_FULL]  = rx_full;
      rd_word[ST_TX_EMPTY] = tx_empty;
      rd_word[ST_TX_FULL]  = tx_full;
      rd_word[ST_RX_OVF]   = rx_ovf;
      rd_word[ST_TX_OVF]   = tx_ovf;
    end else if (hit_count) begin
      rd_word[7:0]  = 8'(rx_count);
      rd_word[15:8] = 8'(tx_count);
    end else if (hit_ctrl) begin
      rd_word[CTRL_IRQ_EN] = irq_en;
    end
  end

  // Stage p0 -> p1: capture the addressed word at the access edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_p1  <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      rd_vld_p1  <= rd_acc;
      rd_data_p1 <= rd_word;
    end
  end

  // Stage p1 -> bus: present read data one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_rvalid <= 1'b0;
      bus_rdata  <= '0;
    end else begin
      bus_rvalid <= rd_vld_p1;
      bus_rdata  <= rd_data_p1;
    end
  end

  // Control registers: sticky flags (a new event beats a clear), irq.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_acc && hit_ctrl) irq_en <= bus_wdata[CTRL_IRQ_EN];
      rx_ovf <= (rx_ovf & ~clr_ovf) | rx_ovf_set;
      tx_ovf <= (tx_ovf & ~clr_ovf) | tx_ovf_set;
      irq    <= irq_en & ~rx_empty;
    end
  end

  // TX engine. A flush in IDLE suppresses the pop so the flushed head is not
  // sent; a frame already in WAIT always runs to completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_pop  = 1'b0;
    start_d = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!tx_empty && !flush) begin
          tx_pop  = 1'b1;
          start_d = 1'b1;
          cnt_d   = CNT_W'(CLKS_PER_FRAME - 1);
          state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (cnt_q == '0) state_d = TX_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= TX_IDLE;
      cnt_q         <= '0;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= 8'h00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      uart_tx_start <= start_d;
      if (tx_pop) uart_tx_data <= tx_dout;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio
// Directed scenarios plus randomized traffic against a queue-based model of
// the peripheral; outputs are compared every cycle on the falling edge.
module tb_uart_mmio;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int FL    = 4;
  localparam int C     = 20;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bus_en = 1'b0;
  logic          bus_we = 1'b0;
  logic [AW-1:0] bus_addr = '0;
  logic [DW-1:0] bus_wdata = '0;
  logic [DW-1:0] bus_rdata;
  logic          bus_rvalid;
  logic [7:0]    uart_rx_data = 8'h00;
  logic          uart_rx_last = 1'b0;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_start;
  logic          irq;

  uart_mmio #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .FIFO_DEPTH_LOG2(FL), .CLKS_PER_FRAME(C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_en(bus_en), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid), .uart_rx_data(uart_rx_data),
    .uart_rx_last(uart_rx_last), .uart_tx_data(uart_tx_data),
    .uart_tx_start(uart_tx_start), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int start_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned rxq[$];
  byte unsigned txq[$];
  bit  m_rx_ovf, m_tx_ovf, m_irq_en;
  int  m_busy;
  bit  pend_vld;
  logic [31:0] pend_data;
  bit  e_rvalid, e_start, e_irq;
  logic [31:0] e_rdata;
  logic [7:0]  e_txdata;
  // per-edge temporaries
  bit  t_rd, t_wr, t_flush, t_clr, t_rx_pop, t_tx_pop, t_rx_set, t_tx_set;
  int  t_rxn, t_txn;
  logic [31:0] t_rv;

  always @(posedge clk) begin
    if (!rst_n) begin
      rxq.delete(); txq.delete();
      m_rx_ovf = 0; m_tx_ovf = 0; m_irq_en = 0; m_busy = 0;
      pend_vld = 0; pend_data = '0;
      e_rvalid = 0; e_rdata = '0; e_start = 0; e_txdata = 8'h00; e_irq = 0;
    end else begin
      t_rxn   = rxq.size();
      t_txn   = txq.size();
      t_rd    = bus_en && !bus_we;
      t_wr    = bus_en && bus_we;
      t_flush = t_wr && bus_addr == 4'hC && bus_wdata[2];
      t_clr   = t_wr && bus_addr == 4'hC && bus_wdata[1];
      t_rv = '0;
      case (bus_addr)
        4'h0: t_rv = (t_rxn > 0) ? 32'(rxq[0]) : 32'd0;
        4'h4: t_rv = {26'd0, m_tx_ovf, m_rx_ovf, t_txn == DEPTH, t_txn == 0,
                      t_rxn == DEPTH, t_rxn == 0};
        4'h8: t_rv = 32'((t_txn << 8) | t_rxn);
        4'hC: t_rv = {31'd0, m_irq_en};
        default: t_rv = '0;
      endcase
      e_rvalid  = pend_vld;
      e_rdata   = pend_data;
      pend_vld  = t_rd;
      pend_data = t_rv;
      e_irq     = m_irq_en && (t_rxn > 0);
      // RX side
      t_rx_pop = t_rd && bus_addr == 4'h0 && t_rxn > 0;
      t_rx_set = uart_rx_last && t_rxn == DEPTH && !t_rx_pop;
      if (t_rx_pop) void'(rxq.pop_front());
      if (uart_rx_last && !t_rx_set) rxq.push_back(uart_rx_data);
      // TX side: a frame occupies the engine for C cycles after its start
      e_start  = 0;
      t_tx_pop = (m_busy == 0) && t_txn > 0 && !t_flush;
      if (t_tx_pop) begin
        e_txdata = txq.pop_front();
        e_start  = 1;
        m_busy   = C;
      end else if (m_busy > 0) begin
        m_busy--;
      end
      t_tx_set = t_wr && bus_addr == 4'h0 && t_txn == DEPTH && !t_tx_pop;
      if (t_wr && bus_addr == 4'h0 && !t_tx_set) txq.push_back(bus_wdata[7:0]);
      if (t_flush) begin rxq.delete(); txq.delete(); end
      if (t_wr && bus_addr == 4'hC) m_irq_en = bus_wdata[0];
      m_rx_ovf = (m_rx_ovf && !t_clr) || t_rx_set;
      m_tx_ovf = (m_tx_ovf && !t_clr) || t_tx_set;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (uart_tx_start === 1'b1) start_cnt++;
    if (chk_en) begin
      check("rvalid", {31'd0, bus_rvalid}, {31'd0, e_rvalid});
      if (e_rvalid) check("rdata", bus_rdata, e_rdata);
      check("tx_start", {31'd0, uart_tx_start}, {31'd0, e_start});
      check("tx_data", {24'd0, uart_tx_data}, {24'd0, e_txdata});
      check("irq", {31'd0, irq}, {31'd0, e_irq});
    end
  end

  // ---------------- bus helpers (called at a falling edge) ----------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_en = 1; bus_we = 1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_en = 0; bus_we = 0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_en = 1; bus_we = 0; bus_addr = a;
    @(negedge clk);
    bus_en = 0;
    @(negedge clk);
    d = bus_rdata;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_rx_data = b; uart_rx_last = 1;
    @(negedge clk);
    uart_rx_last = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rvalid"}, {31'd0, bus_rvalid}, 32'd0);
    check({tag, "_rdata"}, bus_rdata, 32'd0);
    check({tag, "_start"}, {31'd0, uart_tx_start}, 32'd0);
    check({tag, "_txdata"}, {24'd0, uart_tx_data}, 32'd0);
    check({tag, "_irq"}, {31'd0, irq}, 32'd0);
  endtask

  logic [31:0] rd;
  int base;

  initial begin
    // reset
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check_outputs_zero("reset");
    rst_n = 1;
    bus_read(4'h4, rd); check("status_after_reset", rd, 32'h05);
    bus_read(4'h8, rd); check("count_after_reset", rd, 32'h0);
    check("irq_after_reset", {31'd0, irq}, 32'd0);

    // back-to-back TX frames
    bus_write(4'h0, 32'h41);
    bus_write(4'h0, 32'h42);
    check("tx_first_start", {31'd0, uart_tx_start}, 32'd1);
    check("tx_first_data", {24'd0, uart_tx_data}, 32'h41);
    repeat (C + 1) @(negedge clk);
    check("tx_second_start", {31'd0, uart_tx_start}, 32'd1);
    check("tx_second_data", {24'd0, uart_tx_data}, 32'h42);
    bus_read(4'h4, rd); check("status_tx_drained", rd, 32'h05);
    repeat (C) @(negedge clk);

    // RX fill with overflow, interrupt, drain
    bus_write(4'hC, 32'h1);
    for (int i = 0; i < 17; i++) rx_byte(8'(i));
    @(negedge clk);
    check("irq_rx_full", {31'd0, irq}, 32'd1);
    bus_read(4'h4, rd); check("status_rx_ovf", rd, 32'h16);
    for (int i = 0; i < 16; i++) begin
      bus_read(4'h0, rd); check("rx_drain", rd, 32'(i));
    end
    bus_read(4'h0, rd); check("rx_read_empty", rd, 32'h0);
    check("irq_dropped", {31'd0, irq}, 32'd0);

    // full RX FIFO: push and pop in the same cycle
    bus_write(4'hC, 32'h3);
    for (int i = 0; i < 16; i++) rx_byte(8'(8'h80 + i));
    uart_rx_data = 8'hEE; uart_rx_last = 1;
    bus_en = 1; bus_we = 0; bus_addr = 4'h0;
    @(negedge clk);
    uart_rx_last = 0; bus_en = 0;
    @(negedge clk);
    check("rx_simul_head", bus_rdata, 32'h80);
    bus_read(4'h8, rd); check("count_simul", rd, 32'h10);
    bus_read(4'h4, rd); check("status_simul_no_ovf", rd, 32'h06);

    // flush mid-frame
    base = start_cnt;
    bus_write(4'h0, 32'h01);
    bus_write(4'h0, 32'h02);
    bus_write(4'h0, 32'h03);
    repeat (C / 2) @(negedge clk);
    bus_write(4'hC, 32'h6);
    bus_read(4'h8, rd); check("count_after_flush", rd, 32'h0);
    bus_read(4'h4, rd); check("status_after_flush", rd, 32'h05);
    repeat (3 * C) @(negedge clk);
    check("starts_after_flush", 32'(start_cnt - base), 32'd1);

    // reset during WAIT
    bus_write(4'h0, 32'h33);
    repeat (5) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check_outputs_zero("midframe_reset");
    rst_n = 1;
    bus_write(4'h0, 32'h5A);
    @(negedge clk);
    check("post_reset_start", {31'd0, uart_tx_start}, 32'd1);
    check("post_reset_data", {24'd0, uart_tx_data}, 32'h5A);
    repeat (2 * C) @(negedge clk);

    // randomized traffic
    for (int cyc = 0; cyc < 5000; cyc++) begin
      int sel;
      bus_en = ($urandom_range(0, 2) == 0);
      bus_we = $urandom_range(0, 1) == 1;
      sel = $urandom_range(0, 9);
      if (sel < 4)      bus_addr = 4'h0;
      else if (sel < 6) bus_addr = 4'h4;
      else if (sel < 7) bus_addr = 4'h8;
      else if (sel < 9) bus_addr = 4'hC;
      else              bus_addr = 4'($urandom_range(0, 15));
      bus_wdata = $urandom;
      if (bus_addr == 4'hC && $urandom_range(0, 15) != 0) bus_wdata[2] = 1'b0;
      uart_rx_last = ($urandom_range(0, 3) == 0);
      uart_rx_data = 8'($urandom_range(0, 255));
      rst_n = ($urandom_range(0, 1999) != 0);
      @(negedge clk);
    end
    bus_en = 0; bus_we = 0; uart_rx_last = 0; rst_n = 1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
